ls49_input_conditioner: RTL

- Upstream stage of the SN74LS49 seven-segment decoder.
- Takes the raw asynchronous header inputs (BCD bits A–D and the active-low blanking input) and synchronizes each one to clk, then debounces it.
- Outputs a clean registered nibble, a blanking level and a one-cycle change strobe. The decoder instances in the top level consume these instead of the raw pins.

---
 rtl/ls49_input_conditioner.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ls49_input_conditioner.sv
// Synchronizes and debounces the raw SN74LS49 header inputs into a clean digit/blanking pair.
// Optional self-test digit stepper is compiled in with `define LS49_SELF_TEST_EN.
module ls49_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned STEP_CYCLES     = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_a,
   input  logic       raw_b,
   input  logic       raw_c,
   input  logic       raw_d,
   input  logic       raw_bi_n,
   input  logic       self_test,
   output logic [3:0] digit,
   output logic       bi_n,
   output logic       changed
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Bit order {bi_n, d, c, b, a} so the low nibble is the BCD digit.
   logic [4:0]    raw;
   logic [4:0]    sync1;
   logic [4:0]    sync2;
   logic [4:0]    stable;
   logic [CW-1:0] cnt [5];
   logic [3:0]    sel_digit;
   logic          sel_bi_n;

   assign raw = {raw_bi_n, raw_d, raw_c, raw_b, raw_a};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable <= '0;
         for (int unsigned i = 0; i < 5; i++) cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 5; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef LS49_SELF_TEST_EN
   localparam int unsigned PW = $clog2(STEP_CYCLES) + 1;
   localparam logic [PW-1:0] STEP_LAST = PW'(STEP_CYCLES - 1);

   logic          st_sync1;
   logic          st_sync2;
   logic [PW-1:0] presc;
   logic [3:0]    step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_sync1 <= 1'b0;
         st_sync2 <= 1'b0;
      end else begin
         st_sync1 <= self_test;
         st_sync2 <= st_sync1;
      end
   end

   // Held at zero outside self-test, so entry always starts from digit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         step  <= '0;
      end else if (!st_sync2) begin
         presc <= '0;
         step  <= '0;
      end else if (presc == STEP_LAST) begin
         presc <= '0;
         step  <= step + 4'd1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   always_comb begin
      sel_digit = stable[3:0];
      sel_bi_n  = stable[4];
      if (st_sync2) begin
         sel_digit = step;
         sel_bi_n  = 1'b1;
      end
   end
`else
   logic unused_self_test;
   assign unused_self_test = self_test;

   always_comb begin
      sel_digit = stable[3:0];
      sel_bi_n  = stable[4];
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit   <= '0;
         bi_n    <= 1'b0;
         changed <= 1'b0;
      end else begin
         digit   <= sel_digit;
         bi_n    <= sel_bi_n;
         changed <= (sel_digit != digit) || (sel_bi_n != bi_n);
      end
   end

endmodule
